irq_controller: RTL and testbench

//  Interrupt source side of the CP0 interrupt interface. Collects N_IRQ external

---
 rtl/irq_controller_if.sv | 22 ++
 rtl/irq_controller.sv | 166 ++++++++++++++++
 tb/tb_irq_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// irq_controller_if: software register port of the interrupt controller.
// master drives reg_we/reg_addr/reg_din; slave returns registered reg_dout.
interface irq_controller_if;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_din;
  logic [31:0] reg_dout;

  modport master (
    output reg_we,
    output reg_addr,
    output reg_din,
    input  reg_dout
  );

  modport slave (
    input  reg_we,
    input  reg_addr,
    input  reg_din,
    output reg_dout
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: edge-detected sticky pending bits, mask, fixed-priority
// (lowest index wins) arbitration and a one-cycle ir_out pulse into CP0.
// Ports: i_clk, i_rst (sync, active-high), i_irq_src[N_IRQ], i_eret_ack,
//   o_ir_out, o_irq_id[4], bus (irq_controller_if.slave register port).
// Registers: 0 PENDING (W1C), 1 MASK, 2 STATUS, 3 TIMER_CMP.
// Optional: define IRQ_TIMER_EN to add the periodic tick timer on pending[0].
module irq_controller #(
  parameter int N_IRQ   = 8,
  parameter int TIMER_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq_src,
  input  logic             i_eret_ack,
  output logic             o_ir_out,
  output logic [3:0]       o_irq_id,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SERVICE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [3:0]       r_irq_id;
  logic             r_ir_out;
  logic [31:0]      r_dout;

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_req;
  logic [N_IRQ-1:0] w_grant;
  logic [N_IRQ-1:0] w_clr;
  logic [3:0]       w_sel;
  logic             w_take;
  logic             w_tick;
  logic             w_in_service;
  logic             w_wr_pend;
  logic             w_wr_mask;
  logic [31:0]      w_cmp_rd;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_wr_pend = bus.reg_we &
                     (bus.reg_addr == 2'd0);
  assign w_wr_mask = bus.reg_we &
                     (bus.reg_addr == 2'd1);

  assign w_edge = i_irq_src & ~r_prev;
  assign w_set  = w_edge | N_IRQ'(w_tick);
  assign w_req  = r_pending & r_mask;

  // x & -x isolates the lowest set bit.
  assign w_grant = w_take ?
    (w_req & (~w_req + N_IRQ'(1))) : '0;

  assign w_clr = w_wr_pend ?
    bus.reg_din[N_IRQ-1:0] : '0;

  assign w_in_service = (r_state == S_SERVICE);

  always_comb begin
    w_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel = 4'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_take      = 1'b1;
          w_state_nxt = S_ASSERT;
        end
      end
      S_ASSERT:  w_state_nxt = S_SERVICE;
      S_SERVICE: begin
        if (i_eret_ack) w_state_nxt = S_IDLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Set is ORed last so a fresh edge beats both W1C and the grant clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_irq_id  <= '0;
      r_ir_out  <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_prev    <= i_irq_src;
      r_pending <= (r_pending & ~w_clr & ~w_grant)
                   | w_set;
      if (w_wr_mask)
        r_mask <= bus.reg_din[N_IRQ-1:0];
      if (w_take) r_irq_id <= w_sel;
      r_ir_out  <= (r_state == S_ASSERT);
      r_dout    <= w_rd;
    end
  end

  always_comb begin
    w_rd = '0;
    unique case (bus.reg_addr)
      2'd0:    w_rd = 32'(r_pending);
      2'd1:    w_rd = 32'(r_mask);
      2'd2:    w_rd = {27'b0, w_in_service,
                       r_irq_id};
      default: w_rd = w_cmp_rd;
    endcase
  end

`ifdef IRQ_TIMER_EN
  logic [TIMER_W-1:0] r_cnt;
  logic [TIMER_W-1:0] r_cmp;
  logic               w_wr_cmp;

  assign w_wr_cmp = bus.reg_we &
                    (bus.reg_addr == 2'd3);
  assign w_tick   = (r_cmp != '0) &&
                    (r_cnt == r_cmp);
  assign w_cmp_rd = 32'(r_cmp);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_cmp <= '0;
    end else if (w_wr_cmp) begin
      r_cmp <= bus.reg_din[TIMER_W-1:0];
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else if (r_cmp != '0) begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end
`else
  assign w_tick   = 1'b0;
  assign w_cmp_rd = '0;
`endif

  assign w_unused = ^{bus.reg_din, 1'(TIMER_W)};

  assign o_ir_out     = r_ir_out;
  assign o_irq_id     = r_irq_id;
  assign bus.reg_dout = r_dout;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed scenarios plus randomized traffic checked
// against a behavioural model of the interrupt controller.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src;
  logic       eret;
  logic       ir_out;
  logic [3:0] irq_id;

  irq_controller_if bus ();

  irq_controller #(.N_IRQ(8), .TIMER_W(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_irq_src  (src),
    .i_eret_ack (eret),
    .o_ir_out   (ir_out),
    .o_irq_id   (irq_id),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Model: m_age = -1 idle, 0 pulse pending, 1 in service.
  bit [7:0]  m_pend, m_mask, m_prev;
  int        m_age = -1;
  bit [3:0]  m_id;
  bit [31:0] m_dout, m_cmp, m_cnt;
  bit        m_ir;
  int        n_chk = 0;
  int        n_pass = 0;

  task automatic model_step();
    bit [7:0] req, edges;
    bit tk;
    int k;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_age = -1;
      m_id = 0; m_dout = 0; m_ir = 0; m_cmp = 0; m_cnt = 0;
      return;
    end
    case (bus.reg_addr)
      2'd0: m_dout = {24'b0, m_pend};
      2'd1: m_dout = {24'b0, m_mask};
      2'd2: m_dout = {27'b0, (m_age >= 1), m_id};
      default: m_dout = m_cmp;
    endcase
    m_ir = (m_age == 0);
    edges = src & ~m_prev;
    m_prev = src;
    tk = (m_cmp != 0) && (m_cnt == m_cmp);
    req = m_pend & m_mask;
    k = -1;
    if (m_age == -1)
      for (int i = 7; i >= 0; i--) if (req[i]) k = i;
    if (k >= 0) begin
      m_id = 4'(k); m_age = 0; m_pend[k] = 1'b0;
    end else if (m_age == 0) m_age = 1;
    else if (m_age == 1 && eret) m_age = -1;
    if (bus.reg_we && bus.reg_addr == 2'd0)
      m_pend = m_pend & ~bus.reg_din[7:0];
    m_pend = m_pend | edges;
    m_pend[0] = m_pend[0] | tk;
    if (bus.reg_we && bus.reg_addr == 2'd1)
      m_mask = bus.reg_din[7:0];
`ifdef IRQ_TIMER_EN
    if (bus.reg_we && bus.reg_addr == 2'd3) begin
      m_cmp = bus.reg_din; m_cnt = 0;
    end else if (tk) m_cnt = 0;
    else if (m_cmp != 0) m_cnt = m_cnt + 1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input bit [1:0] a, input bit [31:0] d);
    bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_din = d;
    tick();
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input bit [1:0] a, output bit [31:0] v);
    bus.reg_we = 1'b0; bus.reg_addr = a;
    tick();
    v = bus.reg_dout;
  endtask

  task automatic wait_pulse(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ir_out) begin got = 1'b1; return; end
    end
  endtask

  task automatic count_pulses(input int n, output int c, output bit [3:0] id);
    c = 0; id = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ir_out) begin c++; id = irq_id; end
    end
  endtask

  task automatic ack();
    eret = 1'b1; tick(); eret = 1'b0;
  endtask

  task automatic test_reset();
    bit [31:0] v;
    rst = 1'b1; src = 0; eret = 0;
    bus.reg_we = 0; bus.reg_addr = 0; bus.reg_din = 0;
    tick(); tick();
    rst = 1'b0;
    n_chk++; if (ir_out !== 1'b0) $display("FAIL rst_ir_out: got %0b want 0", ir_out); else n_pass++;
    n_chk++; if (irq_id !== 4'd0) $display("FAIL rst_irq_id: got %0d want 0", irq_id); else n_pass++;
    n_chk++; if (bus.reg_dout !== 32'd0) $display("FAIL rst_dout: got %0h want 0", bus.reg_dout); else n_pass++;
    rd(2'd1, v);
    n_chk++; if (v !== 32'd0) $display("FAIL rst_mask: got %0h want 0", v); else n_pass++;
    rd(2'd2, v);
    n_chk++; if (v !== 32'd0) $display("FAIL rst_status: got %0h want 0", v); else n_pass++;
  endtask

  task automatic test_mask_gate();
    bit [31:0] v; int c; bit [3:0] id;
    src = 8'h08; tick();
    rd(2'd0, v);
    n_chk++; if (v !== 32'h08) $display("FAIL masked_pending: got %0h want 8", v); else n_pass++;
    count_pulses(4, c, id);
    n_chk++; if (c !== 0) $display("FAIL masked_no_pulse: got %0d want 0", c); else n_pass++;
    wr(2'd1, 32'h08);
    count_pulses(8, c, id);
    n_chk++; if (c !== 1) $display("FAIL unmask_pulses: got %0d want 1", c); else n_pass++;
    n_chk++; if (id !== 4'd3) $display("FAIL unmask_id: got %0d want 3", id); else n_pass++;
    ack(); src = 0; tick();
  endtask

  task automatic test_priority();
    bit got; int c; bit [3:0] id;
    wr(2'd1, 32'hFF);
    src = 8'h24;
    wait_pulse(got);
    n_chk++; if (!got || irq_id !== 4'd2) $display("FAIL prio_first: got %0b/%0d want 1/2", got, irq_id); else n_pass++;
    count_pulses(5, c, id);
    n_chk++; if (c !== 0) $display("FAIL prio_hold: got %0d want 0", c); else n_pass++;
    ack();
    wait_pulse(got);
    n_chk++; if (!got || irq_id !== 4'd5) $display("FAIL prio_second: got %0b/%0d want 1/5", got, irq_id); else n_pass++;
    ack(); src = 0; tick();
  endtask

  task automatic test_no_nesting();
    bit got; int c, n; bit [3:0] id;
    src = 8'h40;
    wait_pulse(got);
    n_chk++; if (!got || irq_id !== 4'd6) $display("FAIL nest_first: got %0b/%0d want 1/6", got, irq_id); else n_pass++;
    src = 8'h42;
    count_pulses(6, c, id);
    n_chk++; if (c !== 0) $display("FAIL nest_blocked: got %0d want 0", c); else n_pass++;
    eret = 1'b1; tick(); eret = 1'b0;
    n = 1;
    while (!ir_out && n < 10) begin tick(); n++; end
    n_chk++; if (n !== 3 || !ir_out) $display("FAIL nest_latency: got %0d want 3", n); else n_pass++;
    n_chk++; if (irq_id !== 4'd1) $display("FAIL nest_id: got %0d want 1", irq_id); else n_pass++;
    ack(); src = 0; tick();
  endtask

  task automatic test_w1c_race();
    bit [31:0] v;
    wr(2'd1, 32'h0);
    wr(2'd0, 32'hFF);
    src = 8'h10;
    wr(2'd0, 32'h10);
    rd(2'd0, v);
    n_chk++; if (v !== 32'h10) $display("FAIL set_beats_w1c: got %0h want 10", v); else n_pass++;
    wr(2'd0, 32'h10);
    rd(2'd0, v);
    n_chk++; if (v !== 32'h0) $display("FAIL w1c_clear: got %0h want 0", v); else n_pass++;
    src = 0; tick();
  endtask

  task automatic test_rst_in_service();
    bit got; bit [31:0] v; int c; bit [3:0] id;
    wr(2'd1, 32'hFF);
    src = 8'h80;
    wait_pulse(got);
    src = 8'h81; tick();
    rst = 1'b1; src = 0; tick(); rst = 1'b0;
    n_chk++; if (ir_out !== 1'b0) $display("FAIL rst_svc_ir: got %0b want 0", ir_out); else n_pass++;
    n_chk++; if (irq_id !== 4'd0) $display("FAIL rst_svc_id: got %0d want 0", irq_id); else n_pass++;
    rd(2'd0, v);
    n_chk++; if (v !== 32'd0) $display("FAIL rst_svc_pend: got %0h want 0", v); else n_pass++;
    rd(2'd1, v);
    n_chk++; if (v !== 32'd0) $display("FAIL rst_svc_mask: got %0h want 0", v); else n_pass++;
    rd(2'd2, v);
    n_chk++; if (v !== 32'd0) $display("FAIL rst_svc_status: got %0h want 0", v); else n_pass++;
    ack();
    count_pulses(5, c, id);
    rd(2'd2, v);
    n_chk++; if (c !== 0 || v !== 32'd0) $display("FAIL rst_svc_eret: got %0d/%0h want 0/0", c, v); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      src = src ^ 8'($urandom & $urandom & $urandom);
      bus.reg_we = ($urandom_range(0, 5) == 0);
      bus.reg_addr = 2'($urandom);
      bus.reg_din = (bus.reg_addr == 2'd3) ?
        32'($urandom_range(0, 20)) : $urandom;
      eret = ($urandom_range(0, 4) == 0);
      tick();
      n_chk++; if (ir_out !== m_ir) $display("FAIL rnd_ir_out @%0d: got %0b want %0b", i, ir_out, m_ir); else n_pass++;
      n_chk++; if (irq_id !== m_id) $display("FAIL rnd_irq_id @%0d: got %0d want %0d", i, irq_id, m_id); else n_pass++;
      n_chk++; if (bus.reg_dout !== m_dout) $display("FAIL rnd_dout @%0d: got %0h want %0h", i, bus.reg_dout, m_dout); else n_pass++;
    end
    rst = 0; bus.reg_we = 0; eret = 0; src = 0;
  endtask

`ifdef IRQ_TIMER_EN
  task automatic test_timer();
    int last, nint, bad, c; bit [3:0] id;
    rst = 1'b1; tick(); rst = 1'b0;
    wr(2'd1, 32'h01);
    wr(2'd3, 32'd10);
    last = -1; nint = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_chk++; if (ir_out !== m_ir) $display("FAIL tmr_ir @%0d: got %0b want %0b", i, ir_out, m_ir); else n_pass++;
      eret = ir_out;
      if (ir_out) begin
        if (last >= 0 && i - last != 11) bad++;
        last = i; nint++;
      end
    end
    n_chk++; if (nint < 4 || bad != 0) $display("FAIL tmr_period: got %0d pulses %0d bad want >=4/0", nint, bad); else n_pass++;
    wr(2'd3, 32'd0);
    eret = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    eret = 1'b0;
    count_pulses(40, c, id);
    n_chk++; if (c !== 0) $display("FAIL tmr_off: got %0d want 0", c); else n_pass++;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mask_gate();
    test_priority();
    test_no_nesting();
    test_w1c_race();
    test_rst_in_service();
    test_random();
`ifdef IRQ_TIMER_EN
    test_timer();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
